// File: rtl/boot_prog_loader.sv
// boot_prog_loader: boot-time memory programming controller.
//
// Assembles bytes from the boot UART receiver into DATA_W-bit words (little-endian)
// and writes them sequentially into one of NUM_BANKS SRAM write ports. The bank
// is chosen by the first (header) byte of a load. The system reset is held low
// while loading and released only after a clean end-of-program marker.
// A byte timeout, prog_i abort, address overflow and bad header all end in ERR.
//
// Optional feature: define BOOT_PROG_LOADER_CKSUM_EN to require a trailing
// checksum word (sum mod 2**DATA_W of all written words) after END_WORD.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous, active-high reset
//   prog_i      programming request (level); rising edge starts a load
//   rx_dv_i     one-cycle strobe, rx_byte_i valid
//   rx_byte_i   received UART byte
//   we_o        one-hot write strobe per bank
//   addr_o      word write address
//   wdata_o     write data
//   sys_rst_no  active-low reset for core and peripherals
//   busy_o      load in progress
//   done_o      sticky, last load completed successfully
//   err_o       sticky, last load failed
//   word_cnt_o  words written in the current/last load
module boot_prog_loader #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 12,
   parameter int unsigned       NUM_BANKS   = 2,
   parameter logic [DATA_W-1:0] END_WORD    = DATA_W'(32'h0000_0FFF),
   parameter int unsigned       TIMEOUT_CYC = 1_000_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 prog_i,
   input  logic                 rx_dv_i,
   input  logic [7:0]           rx_byte_i,
   output logic [NUM_BANKS-1:0] we_o,
   output logic [ADDR_W-1:0]    addr_o,
   output logic [DATA_W-1:0]    wdata_o,
   output logic                 sys_rst_no,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ADDR_W:0]      word_cnt_o
);

   localparam int unsigned BPW    = DATA_W / 8;
   localparam int unsigned IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPW - 1);
   localparam logic [TMO_W-1:0]  TMO_LIM   = TMO_W'(TIMEOUT_CYC);
   localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HDR   = 3'd1;
   localparam logic [2:0] BYTES = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
   localparam logic [2:0] CKSUM = 3'd6;
`endif

   logic [2:0]           state_q, state_d;
   logic                 prog_q;
   logic [BANK_W-1:0]    bank_q, bank_d;
   logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
   logic [DATA_W-1:0]    word_q, word_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [NUM_BANKS-1:0] we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic                 srst_n_q, srst_n_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ADDR_W:0]      cnt_q, cnt_d;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
   logic [DATA_W-1:0]    cksum_q, cksum_d;
`endif

   logic                 prog_rise;
   logic [TMO_W-1:0]     tmo_inc;
   logic                 tmo_expired;
   logic [DATA_W-1:0]    word_nx;
   logic                 capture;
   logic                 go_err;
   logic                 go_done;

   assign prog_rise   = prog_i & ~prog_q;
   assign tmo_inc     = tmo_q + 1'b1;
   assign tmo_expired = (TIMEOUT_CYC != 0) && (tmo_inc == TMO_LIM);

   // Current word with the incoming byte dropped into its lane.
   always_comb begin
      word_nx = word_q;
      for (int i = 0; i < BPW; i++) begin
         if (byte_idx_q == IDX_W'(i)) word_nx[8*i +: 8] = rx_byte_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      tmo_d      = tmo_q;
      we_d       = '0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      srst_n_d   = srst_n_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
      cksum_d    = cksum_q;
`endif
      capture    = 1'b0;
      go_err     = 1'b0;
      go_done    = 1'b0;

      case (state_q)
         IDLE: srst_n_d = 1'b1;
         HDR: begin
            if (!prog_i || (!rx_dv_i && tmo_expired)) begin
               go_err = 1'b1;
            end else begin
               tmo_d = rx_dv_i ? '0 : tmo_inc;
               if (rx_dv_i) begin
                  if (32'(rx_byte_i) < NUM_BANKS) begin
                     bank_d  = BANK_W'(rx_byte_i);
                     state_d = BYTES;
                  end else begin
                     go_err = 1'b1;
                  end
               end
            end
         end
         BYTES: begin
            if (!prog_i || (!rx_dv_i && tmo_expired)) begin
               go_err = 1'b1;
            end else begin
               tmo_d   = rx_dv_i ? '0 : tmo_inc;
               capture = rx_dv_i;
            end
         end
         WRITE: begin
            // The strobe itself was issued on entry; here the bookkeeping follows.
            if (!prog_i) begin
               go_err = 1'b1;
            end else if (word_q == END_WORD) begin
`ifdef BOOT_PROG_LOADER_CKSUM_EN
               state_d = CKSUM;
               tmo_d   = '0;
`else
               go_done = 1'b1;
`endif
            end else if (cnt_q == DEPTH_CNT) begin
               go_err = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               // Saturate: a full bank is caught by the count, never by wrapping.
               if (addr_q != '1) addr_d = addr_q + 1'b1;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
               cksum_d = cksum_q + word_q;
`endif
               state_d = BYTES;
               tmo_d   = '0;
               capture = rx_dv_i;
            end
         end
`ifdef BOOT_PROG_LOADER_CKSUM_EN
         CKSUM: begin
            if (!prog_i || (!rx_dv_i && tmo_expired)) begin
               go_err = 1'b1;
            end else begin
               tmo_d = rx_dv_i ? '0 : tmo_inc;
               if (rx_dv_i) begin
                  word_d = word_nx;
                  if (byte_idx_q == LAST_IDX) begin
                     byte_idx_d = '0;
                     if (word_nx == cksum_q) go_done = 1'b1;
                     else go_err = 1'b1;
                  end else begin
                     byte_idx_d = byte_idx_q + 1'b1;
                  end
               end
            end
         end
`endif
         DONE: ;
         ERR:  ;
         default: state_d = IDLE;
      endcase

      // Write strobe is decided one cycle early so it is registered yet still
      // aligned with the WRITE cycle.
      if (capture) begin
         word_d = word_nx;
         if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            state_d    = WRITE;
            if (word_nx != END_WORD && cnt_d != DEPTH_CNT) begin
               we_d[bank_q] = 1'b1;
               wdata_d      = word_nx;
            end
         end else begin
            byte_idx_d = byte_idx_q + 1'b1;
         end
      end

      if (go_err) begin
         state_d  = ERR;
         err_d    = 1'b1;
         busy_d   = 1'b0;
         srst_n_d = 1'b0;
         we_d     = '0;
      end

      if (go_done) begin
         state_d  = DONE;
         done_d   = 1'b1;
         busy_d   = 1'b0;
         srst_n_d = 1'b1;
      end

      if (prog_rise) begin
         state_d    = HDR;
         done_d     = 1'b0;
         err_d      = 1'b0;
         cnt_d      = '0;
         addr_d     = '0;
         byte_idx_d = '0;
         tmo_d      = '0;
         busy_d     = 1'b1;
         srst_n_d   = 1'b0;
         we_d       = '0;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
         cksum_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         prog_q     <= 1'b0;
         bank_q     <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         tmo_q      <= '0;
         we_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         srst_n_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         prog_q     <= prog_i;
         bank_q     <= bank_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         tmo_q      <= tmo_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         srst_n_q   <= srst_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
`ifdef BOOT_PROG_LOADER_CKSUM_EN
         cksum_q    <= cksum_d;
`endif
      end
   end

   assign we_o       = we_q;
   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign sys_rst_no = srst_n_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_boot_prog_loader.sv
// Directed bench for boot_prog_loader (ADDR_W=2, TIMEOUT_CYC=100).
// Works with or without BOOT_PROG_LOADER_CKSUM_EN defined.
module tb_boot_prog_loader;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned NUM_BANKS   = 2;
   localparam int unsigned TIMEOUT_CYC = 100;
   localparam logic [31:0] END_W       = 32'h0000_0FFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic prog = 1'b0;
   logic rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;

   logic [NUM_BANKS-1:0] we;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;
   logic                 sys_rst_n;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [ADDR_W:0]      word_cnt;

   int tests = 0;
   int fails = 0;

   logic [NUM_BANKS-1:0] log_we[$];
   logic [ADDR_W-1:0]    log_addr[$];
   logic [DATA_W-1:0]    log_data[$];

   boot_prog_loader #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .NUM_BANKS   (NUM_BANKS),
      .END_WORD    (END_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .prog_i     (prog),
      .rx_dv_i    (rx_dv),
      .rx_byte_i  (rx_byte),
      .we_o       (we),
      .addr_o     (addr),
      .wdata_o    (wdata),
      .sys_rst_no (sys_rst_n),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .word_cnt_o (word_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we !== '0) begin
         log_we.push_back(we);
         log_addr.push_back(addr);
         log_data.push_back(wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_dv   = 1'b1;
      tick();
      rx_dv   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   // End marker, plus the checksum word when that option is built in.
   task automatic send_end(input logic [31:0] sum);
      send_word(END_W);
`ifdef BOOT_PROG_LOADER_CKSUM_EN
      send_word(sum);
`else
      if (sum === 32'hx) $display("unused");
`endif
   endtask

   task automatic start_load();
      prog = 1'b0;
      tick();
      prog = 1'b1;
      tick();
      log_we.delete();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic wait_end(input string tag);
      for (int i = 0; i < 50 && !(done || err); i++) tick();
      check({tag, "_finished"}, 64'(done | err), 64'd1);
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      check("rst_we", 64'(we), 64'd0);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_sys_rst_n", 64'(sys_rst_n), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      rst = 1'b0;
      check("idle_pre_edge_sys_rst_n", 64'(sys_rst_n), 64'd0);
      tick();
      check("idle_sys_rst_n", 64'(sys_rst_n), 64'd1);

      // Basic load, bytes streamed back to back (some land in WRITE cycles)
      start_load();
      check("load_busy", 64'(busy), 64'd1);
      check("load_sys_rst_n", 64'(sys_rst_n), 64'd0);
      send_byte(8'h00);
      send_word(32'h1234_5678);
      send_word(32'hDEAD_BEEF);
      send_end(32'hF0E2_1567);
      wait_end("basic");
      check("basic_done", 64'(done), 64'd1);
      check("basic_err", 64'(err), 64'd0);
      check("basic_word_cnt", 64'(word_cnt), 64'd2);
      check("basic_sys_rst_n", 64'(sys_rst_n), 64'd1);
      check("basic_busy", 64'(busy), 64'd0);
      check("basic_nwr", 64'(log_we.size()), 64'd2);
      check("basic_we0", 64'(log_we[0]), 64'd1);
      check("basic_addr0", 64'(log_addr[0]), 64'd0);
      check("basic_data0", 64'(log_data[0]), 64'h1234_5678);
      check("basic_we1", 64'(log_we[1]), 64'd1);
      check("basic_addr1", 64'(log_addr[1]), 64'd1);
      check("basic_data1", 64'(log_data[1]), 64'hDEAD_BEEF);

      // Bank 1
      start_load();
      check("bank_done_cleared", 64'(done), 64'd0);
      check("bank_cnt_cleared", 64'(word_cnt), 64'd0);
      send_byte(8'h01);
      send_word(32'h1122_3344);
      send_end(32'h1122_3344);
      wait_end("bank1");
      check("bank1_done", 64'(done), 64'd1);
      check("bank1_nwr", 64'(log_we.size()), 64'd1);
      check("bank1_we", 64'(log_we[0]), 64'd2);
      check("bank1_addr", 64'(log_addr[0]), 64'd0);
      check("bank1_data", 64'(log_data[0]), 64'h1122_3344);

      // Bad header
      start_load();
      send_byte(8'h05);
      wait_end("badhdr");
      check("badhdr_err", 64'(err), 64'd1);
      check("badhdr_done", 64'(done), 64'd0);
      check("badhdr_sys_rst_n", 64'(sys_rst_n), 64'd0);
      check("badhdr_busy", 64'(busy), 64'd0);
      send_word(32'h0000_0001);
      check("badhdr_nwr", 64'(log_we.size()), 64'd0);

      // Overflow: DEPTH = 4
      start_load();
      send_byte(8'h00);
      for (int k = 1; k <= 5; k++) send_word(32'(k));
      wait_end("ovf");
      check("ovf_err", 64'(err), 64'd1);
      check("ovf_done", 64'(done), 64'd0);
      check("ovf_word_cnt", 64'(word_cnt), 64'd4);
      check("ovf_nwr", 64'(log_we.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ovf_addr%0d", k), 64'(log_addr[k]), 64'(k));
         check($sformatf("ovf_data%0d", k), 64'(log_data[k]), 64'(k + 1));
      end

      // Timeout: err exactly 100 cycles after the last strobe
      start_load();
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (99) tick();
      check("tmo_err_at_99", 64'(err), 64'd0);
      check("tmo_busy_at_99", 64'(busy), 64'd1);
      tick();
      check("tmo_err_at_100", 64'(err), 64'd1);
      check("tmo_busy", 64'(busy), 64'd0);
      check("tmo_sys_rst_n", 64'(sys_rst_n), 64'd0);
      check("tmo_nwr", 64'(log_we.size()), 64'd0);

      // Clean restart after the timeout
      start_load();
      check("restart_err_cleared", 64'(err), 64'd0);
      send_byte(8'h00);
      send_word(32'h0000_0055);
      send_end(32'h0000_0055);
      wait_end("restart");
      check("restart_done", 64'(done), 64'd1);
      check("restart_err", 64'(err), 64'd0);
      check("restart_nwr", 64'(log_we.size()), 64'd1);
      check("restart_data", 64'(log_data[0]), 64'h0000_0055);
      check("restart_word_cnt", 64'(word_cnt), 64'd1);

      // Abort by dropping prog after 3 data bytes
      start_load();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      prog = 1'b0;
      tick();
      check("abort_err", 64'(err), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      send_byte(8'h04);
      tick();
      check("abort_err_hold", 64'(err), 64'd1);
      check("abort_done", 64'(done), 64'd0);
      check("abort_nwr", 64'(log_we.size()), 64'd0);

      // Asynchronous reset mid-word
      start_load();
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      check("midrst_busy_before", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_we", 64'(we), 64'd0);
      check("midrst_addr", 64'(addr), 64'd0);
      check("midrst_wdata", 64'(wdata), 64'd0);
      check("midrst_sys_rst_n", 64'(sys_rst_n), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_word_cnt", 64'(word_cnt), 64'd0);
      prog = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("midrst_idle_sys_rst_n", 64'(sys_rst_n), 64'd1);

`ifdef BOOT_PROG_LOADER_CKSUM_EN
      start_load();
      send_byte(8'h00);
      send_word(32'h1);
      send_word(32'h2);
      send_word(END_W);
      send_word(32'h3);
      wait_end("ck_good");
      check("ck_good_done", 64'(done), 64'd1);
      check("ck_good_err", 64'(err), 64'd0);
      check("ck_good_nwr", 64'(log_we.size()), 64'd2);

      start_load();
      send_byte(8'h00);
      send_word(32'h1);
      send_word(32'h2);
      send_word(END_W);
      send_word(32'h4);
      wait_end("ck_bad");
      check("ck_bad_err", 64'(err), 64'd1);
      check("ck_bad_done", 64'(done), 64'd0);
      check("ck_bad_sys_rst_n", 64'(sys_rst_n), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
